calc_sequencer: RTL and testbench

Front-end controller for the two-digit BCD adder/subtractor. Accepts decoded keypad events, assembles two 2-digit BCD operands and an operation, then drives the combinational ALU. It captures the ALU result and carry into a display register and supports chained, repeated and cleared calculations. It sits between the keypad decoder/debouncer and the ALU/display driver.

---
 rtl/calc_sequencer.sv | 138 +++++++++++++
 tb/tb_calc_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// Keypad-driven sequencer for a two-digit BCD adder/subtractor: assembles operands,
// drives the external ALU and captures its result for display (chain/repeat/clear).
module calc_sequencer (
    input  logic       clock,
    input  logic       nrst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [7:0] alu_op1,
    output logic [7:0] alu_op2,
    output logic [1:0] alu_opcode,
    input  logic [7:0] alu_result,
    input  logic       alu_carry,
    output logic [7:0] display,
    output logic       disp_carry,
    output logic [1:0] mode,
    output logic       done
);

    localparam int unsigned DW  = 8;
    localparam int unsigned OPW = 2;

    localparam logic [OPW-1:0] OPC_ADD = 2'b00;
    localparam logic [OPW-1:0] OPC_SUB = 2'b10;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_EQU = 4'hC;
    localparam logic [3:0] KEY_CLR = 4'hD;

    typedef enum logic [1:0] {
        ST_OP1    = 2'd0,
        ST_OP2    = 2'd1,
        ST_EXEC   = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    state_t         state_q;
    logic [DW-1:0]  op1_q;
    logic [DW-1:0]  op2_q;
    logic [OPW-1:0] opcode_q;
    logic [DW-1:0]  display_q;
    logic           carry_q;
    logic           done_q;

    // Key decode; 4'hE/4'hF match none of these and fall through as no-ops.
    logic           key_digit;
    logic           key_arith;
    logic           key_equ;
    logic           key_clr;
    logic [OPW-1:0] key_opcode;

    always_comb begin
        key_digit  = key_valid && (key_code <= 4'h9);
        key_arith  = key_valid && ((key_code == KEY_ADD) || (key_code == KEY_SUB));
        key_equ    = key_valid && (key_code == KEY_EQU);
        key_clr    = key_valid && (key_code == KEY_CLR);
        key_opcode = (key_code == KEY_SUB) ? OPC_SUB : OPC_ADD;
    end

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state_q   <= ST_OP1;
            op1_q     <= '0;
            op2_q     <= '0;
            opcode_q  <= OPC_ADD;
            display_q <= '0;
            carry_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // EXEC ignores every key, clear included, so the capture cannot be lost.
            if (key_clr && (state_q != ST_EXEC)) begin
                state_q   <= ST_OP1;
                op1_q     <= '0;
                op2_q     <= '0;
                opcode_q  <= OPC_ADD;
                display_q <= '0;
                carry_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_OP1: begin
                        if (key_digit) begin
                            op1_q     <= {op1_q[3:0], key_code};
                            display_q <= {op1_q[3:0], key_code};
                        end else if (key_arith) begin
                            opcode_q <= key_opcode;
                            op2_q    <= '0;
                            state_q  <= ST_OP2;
                        end
                    end
                    ST_OP2: begin
                        if (key_digit) begin
                            op2_q     <= {op2_q[3:0], key_code};
                            display_q <= {op2_q[3:0], key_code};
                        end else if (key_arith) begin
                            opcode_q <= key_opcode;
                        end else if (key_equ) begin
                            state_q <= ST_EXEC;
                        end
                    end
                    ST_EXEC: begin
                        display_q <= alu_result;
                        carry_q   <= alu_carry;
                        done_q    <= 1'b1;
                        state_q   <= ST_RESULT;
                    end
                    ST_RESULT: begin
                        if (key_digit) begin
                            op1_q     <= {4'h0, key_code};
                            op2_q     <= '0;
                            carry_q   <= 1'b0;
                            display_q <= {4'h0, key_code};
                            state_q   <= ST_OP1;
                        end else if (key_arith) begin
                            op1_q    <= display_q;
                            opcode_q <= key_opcode;
                            op2_q    <= '0;
                            state_q  <= ST_OP2;
                        end else if (key_equ) begin
                            op1_q   <= display_q;
                            state_q <= ST_EXEC;
                        end
                    end
                    default: state_q <= ST_OP1;
                endcase
            end
        end
    end

    assign alu_op1    = op1_q;
    assign alu_op2    = op2_q;
    assign alu_opcode = opcode_q;
    assign display    = display_q;
    assign disp_carry = carry_q;
    assign mode       = state_q;
    assign done       = done_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: stimulus pushes expected results, a monitor
// pops and compares whenever done pulses; a BCD ALU reference closes the loop.
module tb_calc_sequencer;

    logic       clock;
    logic       nrst;
    logic       key_valid;
    logic [3:0] key_code;
    logic [7:0] alu_op1;
    logic [7:0] alu_op2;
    logic [1:0] alu_opcode;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic [7:0] display;
    logic       disp_carry;
    logic [1:0] mode;
    logic       done;

    calc_sequencer dut (
        .clock      (clock),
        .nrst       (nrst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .display    (display),
        .disp_carry (disp_carry),
        .mode       (mode),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference two-digit BCD ALU; subtract carry flags a borrow.
    function automatic int from_bcd(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    always_comb begin
        int a, b, r;
        a = from_bcd(alu_op1);
        b = from_bcd(alu_op2);
        if (alu_opcode == 2'b10) begin
            r          = a - b;
            alu_carry  = (r < 0);
            alu_result = to_bcd((r + 100) % 100);
        end else begin
            r          = a + b;
            alu_carry  = (r >= 100);
            alu_result = to_bcd(r % 100);
        end
    end

    typedef struct {
        logic [7:0] disp;
        logic       carry;
        logic [7:0] op1;
        logic [7:0] op2;
        logic [1:0] opc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h required 0x%h", name, act, exp);
    endtask

    task automatic press(input logic [3:0] code);
        @(negedge clock);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clock);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic c, input logic [7:0] o1,
                            input logic [7:0] o2, input logic [1:0] opc);
        exp_t e;
        e.disp = d; e.carry = c; e.op1 = o1; e.op2 = o2; e.opc = opc;
        exp_q.push_back(e);
    endtask

    // Bounded wait for the monitor to consume every queued result.
    task automatic wait_done(input string name);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0) return;
        end
        n_checks++;
        $display("FAIL %s: result not captured within 8 cycles, %0d pending", name, exp_q.size());
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_op1"}, alu_op1, 8'h00);
        check({name, "_op2"}, alu_op2, 8'h00);
        check({name, "_opc"}, 8'(alu_opcode), 8'h00);
        check({name, "_disp"}, display, 8'h00);
        check({name, "_carry"}, 8'(disp_carry), 8'h00);
        check({name, "_done"}, 8'(done), 8'h00);
        check({name, "_mode"}, 8'(mode), 8'h00);
    endtask

    // Monitor: every done pulse must match the oldest expectation and last one cycle.
    initial begin
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clock);
            if (prev_done) check("done_pulse_width", 8'(done), 8'h00);
            else if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_done: display 0x%h with no result expected", display);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("res_display", display, e.disp);
                    check("res_carry", 8'(disp_carry), 8'(e.carry));
                    check("res_op1", alu_op1, e.op1);
                    check("res_op2", alu_op2, e.op2);
                    check("res_opcode", 8'(alu_opcode), 8'(e.opc));
                    check("res_mode", 8'(mode), 8'h03);
                end
            end
            prev_done = (done === 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        key_valid = 1'b0;
        key_code  = 4'h0;
        nrst      = 1'b0;
        repeat (2) @(negedge clock);
        check_all_zero("reset");
        nrst = 1'b1;

        // 12 + 34
        press(4'h1); press(4'h2);
        check("op1_12", alu_op1, 8'h12);
        check("disp_op1_12", display, 8'h12);
        press(4'hA);
        check("mode_op2", 8'(mode), 8'h01);
        check("disp_keeps_op1", display, 8'h12);
        press(4'h3); press(4'h4);
        check("op2_34", alu_op2, 8'h34);
        check("disp_op2_34", display, 8'h34);
        push_exp(8'h46, 1'b0, 8'h12, 8'h34, 2'b00);
        press(4'hC);
        check("mode_exec", 8'(mode), 8'h02);
        check("done_low_in_exec", 8'(done), 8'h00);
        wait_done("add_12_34");

        // Chain A,1,C then repeat C
        press(4'hA);
        check("chain_op1", alu_op1, 8'h46);
        check("chain_op2_cleared", alu_op2, 8'h00);
        press(4'h1);
        push_exp(8'h47, 1'b0, 8'h46, 8'h01, 2'b00);
        press(4'hC);
        wait_done("chain");
        push_exp(8'h48, 1'b0, 8'h47, 8'h01, 2'b00);
        press(4'hC);
        wait_done("repeat");

        // Digit in RESULT starts fresh: 50 - 23
        press(4'h5);
        check("fresh_op1", alu_op1, 8'h05);
        check("fresh_mode", 8'(mode), 8'h00);
        check("fresh_op2", alu_op2, 8'h00);
        press(4'h0); press(4'hB);
        check("sub_opcode", 8'(alu_opcode), 8'h02);
        press(4'h2); press(4'h3);
        push_exp(8'h27, 1'b0, 8'h50, 8'h23, 2'b10);
        press(4'hC);
        wait_done("sub_50_23");

        // Clear in RESULT
        press(4'hD);
        check_all_zero("clear");

        // Digit overflow, equals and ignored codes in OP1
        press(4'h1); press(4'h2); press(4'h3);
        check("overflow_op1", alu_op1, 8'h23);
        press(4'hC);
        check("op1_equ_mode", 8'(mode), 8'h00);
        check("op1_equ_done", 8'(done), 8'h00);
        press(4'hE); press(4'hF);
        check("ignored_op1", alu_op1, 8'h23);
        check("ignored_mode", 8'(mode), 8'h00);

        // Carry out: 99 + 02 ; borrow: 10 - 20
        press(4'hD); press(4'h9); press(4'h9); press(4'hA); press(4'h0); press(4'h2);
        push_exp(8'h01, 1'b1, 8'h99, 8'h02, 2'b00);
        press(4'hC);
        wait_done("add_carry");
        press(4'hD); press(4'h1); press(4'h0); press(4'hB); press(4'h2); press(4'h0);
        push_exp(8'h90, 1'b1, 8'h10, 8'h20, 2'b10);
        press(4'hC);
        wait_done("sub_borrow");

        // Key in the EXEC cycle is dropped
        press(4'hD); press(4'h1); press(4'h1); press(4'hA); press(4'h2); press(4'h2);
        push_exp(8'h33, 1'b0, 8'h11, 8'h22, 2'b00);
        @(negedge clock);
        key_valid = 1'b1; key_code = 4'hC;
        @(negedge clock);
        key_code = 4'h7;
        @(negedge clock);
        key_valid = 1'b0; key_code = 4'h0;
        check("drop_op1", alu_op1, 8'h11);
        check("drop_op2", alu_op2, 8'h22);
        wait_done("drop_key");
        check("drop_mode_result", 8'(mode), 8'h03);

        // Asynchronous reset in OP2
        press(4'hD); press(4'h1); press(4'h2); press(4'hA); press(4'h3); press(4'h4);
        check("pre_reset_op2", alu_op2, 8'h34);
        #2 nrst = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clock);
        nrst = 1'b1;

        // Reset while in EXEC: capture discarded, no done
        press(4'h1); press(4'hA); press(4'h2);
        press(4'hC);
        check("exec_before_reset", 8'(mode), 8'h02);
        #1 nrst = 1'b0;
        repeat (3) @(negedge clock);
        check_all_zero("exec_reset");
        nrst = 1'b1;
        repeat (2) @(negedge clock);
        check("exec_reset_no_done", 8'(done), 8'h00);

        check("queue_empty", 8'(exp_q.size()), 8'h00);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
